bp_sacc_io_arbiter: RTL
=======================

# bp_sacc_io_arbiter

Shares one I/O command/response channel pair from the I/O CCE among `num_sacc_p` streaming-accelerator slots inside a SACC tile.

- **Commands:** each command is steered to one slot by address bits. A per-slot outstanding-request counter limits how many commands a slot may have in flight.
- **Responses:** slot responses are merged back round-robin through a registered output stage.
- **Placement:** sits between the I/O CCE's io_cmd/io_resp ports and the accelerator instances.

## Interface
Parameters:
- `bp_params_p`, default `e_bp_inv_cfg`: processor configuration. Provides `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p` and `lce_assoc_p` for `bp_cce_mem_msg_s`.
- `num_sacc_p`, default 2: number of accelerator slots, 1..8.
- `max_outstanding_p`, default 4: maximum in-flight commands per slot.
- `slot_addr_lsb_p`, default 20: LSB of the slot-select field in `header.addr`. Field width is `slot_w = max(1, $clog2(num_sacc_p))`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset. One clock; reset is synchronous and active-high.
- `io_cmd_i` in `$bits(bp_cce_mem_msg_s)`: command from the I/O CCE.
- `io_cmd_v_i` in 1: command valid.
- `io_cmd_ready_o` out 1: command ready (valid/ready handshake).
- `io_resp_o` out `$bits(bp_cce_mem_msg_s)`: merged response to the I/O CCE.
- `io_resp_v_o` out 1: response valid.
- `io_resp_yumi_i` in 1: I/O CCE consumed the response.
- `sacc_io_cmd_o` out `num_sacc_p*$bits(bp_cce_mem_msg_s)`: per-slot command copies.
- `sacc_io_cmd_v_o` out `num_sacc_p`: per-slot command valid.
- `sacc_io_cmd_ready_i` in `num_sacc_p`: per-slot command ready.
- `sacc_io_resp_i` in `num_sacc_p*$bits(bp_cce_mem_msg_s)`: per-slot responses.
- `sacc_io_resp_v_i` in `num_sacc_p`: per-slot response valid.
- `sacc_io_resp_yumi_o` out `num_sacc_p`: per-slot response consumed.

## Operation
**Command routing**
- `slot = io_cmd_i.header.addr[slot_addr_lsb_p +: slot_w]`.
- Every `sacc_io_cmd_o` lane carries `io_cmd_i` unchanged.
- `sacc_io_cmd_v_o[s] = io_cmd_v_i & (slot==s) & (cnt[s] < max_outstanding_p)`.
- For an in-range slot: `io_cmd_ready_o = sacc_io_cmd_ready_i[slot] & (cnt[slot] < max_outstanding_p)`.
- `io_cmd_ready_o` may depend on `io_cmd_i` contents but never on `io_cmd_v_i`.

**Out-of-range slot (slot ≥ `num_sacc_p`)**
- `io_cmd_ready_o` equals "error buffer empty".
- On handshake, the one-entry error buffer captures the header with data zeroed, and the sticky `err_r` flag sets.
- `err_r` is internal, exposed only via bind/assertion, and cleared by reset only.

**Credit counters**
- `cnt[s]` is `$clog2(max_outstanding_p+1)` bits.
- `+1` on a `sacc_io_cmd` handshake for slot `s`.
- `-1` on `sacc_io_resp_yumi_o[s]`.
- Both in the same cycle: unchanged.
- A response from a slot with `cnt==0` is an assertion failure; the counter holds at 0.

**Response merge**
- Requesters are `sacc_io_resp_v_i[0..n-1]` plus the error buffer as requester `n`.
- Round-robin arbitration: the search starts at `last_grant+1` and wraps.
- A grant issues only when the output register can load, i.e. `!io_resp_v_o | io_resp_yumi_i`.
- On grant: the granted `sacc_io_resp_yumi_o` bit is 1 (one-hot or zero), the register loads that response, and `last_grant` updates.

**Reset**
- `io_resp_v_o=0`, `io_cmd_ready_o` is combinational, all `sacc_io_resp_yumi_o=0`, all `sacc_io_cmd_v_o=0` (since `io_cmd_v_i` is don't-care during reset).
- `cnt=0`, `last_grant=num_sacc_p` (slot 0 has first priority), error buffer empty.
- Reset mid-operation discards the output register, the error buffer and all credits.

## Timing
- Command path is combinational: zero-cycle pass-through.
- Response latency: sacc yumi in cycle N, then `io_resp_v_o` in N+1.
- Full throughput is one response per cycle when `io_resp_yumi_i` is held high. Load and drain in the same cycle are permitted.
- Output register held (`io_resp_v_o=1`, no yumi): no grants issue and `io_resp_o` is stable.
- Error buffer entry is visible to arbitration the cycle after capture.
- With all slots continuously valid, each requester is granted at least once every `num_sacc_p+1` grants.

## Structure
- No new package types. `bp_cce_mem_msg_s` comes from the existing `declare_bp_me_if` macro.
- `slot_w` is a localparam.
- Arbitration uses sub-module `bsg_arb_round_robin` with width `num_sacc_p+1`, grant gated by output-register load enable.
- Counters, routing and the output register are written inline.

## Test plan
- **Routing:** `num_sacc_p=2`. Commands to addr `0x0010_0000` then `0x0000_0040` go to slot 1 then slot 0. Each gets one response; `io_resp_o` returns the matching headers one cycle after each yumi.
- **Credit limit:** slot 0 `ready=1`, no responses, 5 commands issued. The first 4 handshake; `io_cmd_ready_o=0` on the 5th until one slot-0 response is yumi'd, then it handshakes.
- **Fairness:** both slots hold `v=1` continuously with `io_resp_yumi_i=1`. Grants alternate 0,1,0,1; `cnt` decrements each grant.
- **Backpressure:** `io_resp_yumi_i=0` for 3 cycles with responses pending. `io_resp_o` is stable, no `sacc_io_resp_yumi_o`; drain resumes the cycle yumi rises.
- **Out-of-range:** `num_sacc_p=3`, addr `0x0030_0000` (slot 3). Handshake completes, a zero-data response with the same header appears, `err_r=1`, and no `sacc_io_cmd_v_o` asserts.
- **Reset mid-flight:** `reset_i` pulsed with 2 commands outstanding and a response registered. The next cycle has `io_resp_v_o=0` and `cnt=0`, and slot 0 wins the first grant afterwards.

Source files
------------

// File: rtl/bp_sacc_io_arbiter_pkg.sv
// Message layout shared by the I/O CCE and the accelerator slots, plus the
// per-configuration helper used to size the message ports.
package bp_sacc_io_arbiter_pkg;

    typedef enum logic [1:0] {
        e_bp_inv_cfg     = 2'd0,
        e_bp_default_cfg = 2'd1
    } bp_params_e;

    localparam int paddr_width_p     = 40;
    localparam int cce_block_width_p = 64;
    localparam int lce_id_width_p    = 4;
    localparam int lce_assoc_p       = 8;

    typedef struct packed {
        logic [lce_id_width_p-1:0]      lce_id;
        logic [$clog2(lce_assoc_p)-1:0] way_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [3:0]               msg_type;
        logic [2:0]               size;
        logic [paddr_width_p-1:0] addr;
        bp_cce_mem_payload_s      payload;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        bp_cce_mem_msg_header_s       header;
        logic [cce_block_width_p-1:0] data;
    } bp_cce_mem_msg_s;

    // Every supported configuration shares one message layout today.
    function automatic int cfg_msg_width(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return $bits(bp_cce_mem_msg_s);
            default:      return $bits(bp_cce_mem_msg_s);
        endcase
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the search starts one past the last grant and wraps.
// A grant is only issued while grants_en_i is high; the pointer moves only
// when a grant is actually issued. Reset points at the top requester so
// requester 0 has first priority.
module bsg_arb_round_robin #(
    parameter int width_p = 2,
    localparam int tag_w = (width_p > 1) ? $clog2(width_p) : 1,
    localparam int idx_w_w = tag_w + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               grants_en_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    output logic               v_o
);

    logic [tag_w-1:0]   last_r;
    logic [tag_w-1:0]   pick;
    logic [tag_w-1:0]   idx;
    logic [idx_w_w-1:0] idx_w;
    logic               found;

    // Find the first requester after last_r, wrapping modulo width_p.
    always_comb begin
        grants_o = '0;
        pick     = last_r;
        idx      = '0;
        idx_w    = '0;
        found    = 1'b0;
        for (int i = 1; i <= width_p; i++) begin
            idx_w = {1'b0, last_r} + idx_w_w'(i);
            if (idx_w >= idx_w_w'(width_p)) begin
                idx_w = idx_w - idx_w_w'(width_p);
            end
            idx = idx_w[tag_w-1:0];
            if (!found && reqs_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        v_o = found & grants_en_i;
        if (v_o) begin
            grants_o[pick] = 1'b1;
        end
    end

    // Remember the winner so the next search starts just past it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r <= tag_w'(width_p - 1);
        end else if (v_o) begin
            last_r <= pick;
        end
    end

endmodule

// File: rtl/bp_sacc_io_arbiter.sv
// Shares one I/O CCE command/response channel pair among num_sacc_p
// accelerator slots. Commands are steered by an address field and limited by
// per-slot credit counters; slot responses (plus an error-buffer entry for
// commands to non-existent slots) merge round-robin into a registered output.
//
// Handshakes: commands use valid/ready -- a transfer happens in any cycle
// where valid and ready are both high; ready never looks at valid. Responses
// use valid/yumi -- the consumer raises yumi only while valid is high, and
// that cycle is the transfer.
module bp_sacc_io_arbiter
    import bp_sacc_io_arbiter_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int num_sacc_p = 2,
    parameter int max_outstanding_p = 4,
    parameter int slot_addr_lsb_p = 20,
    localparam int msg_w = cfg_msg_width(bp_params_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  bp_cce_mem_msg_s               io_cmd_i,
    input  logic                          io_cmd_v_i,
    output logic                          io_cmd_ready_o,
    output bp_cce_mem_msg_s               io_resp_o,
    output logic                          io_resp_v_o,
    input  logic                          io_resp_yumi_i,
    output logic [num_sacc_p*msg_w-1:0]   sacc_io_cmd_o,
    output logic [num_sacc_p-1:0]         sacc_io_cmd_v_o,
    input  logic [num_sacc_p-1:0]         sacc_io_cmd_ready_i,
    input  logic [num_sacc_p*msg_w-1:0]   sacc_io_resp_i,
    input  logic [num_sacc_p-1:0]         sacc_io_resp_v_i,
    output logic [num_sacc_p-1:0]         sacc_io_resp_yumi_o
);

    localparam int slot_w = (num_sacc_p > 1) ? $clog2(num_sacc_p) : 1;
    localparam int slot_cmp_w = slot_w + 1;
    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam int req_n = num_sacc_p + 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_outstanding_p);
    localparam logic [slot_cmp_w-1:0] slot_count = slot_cmp_w'(num_sacc_p);

    logic [slot_w-1:0]     slot;
    logic                  slot_in_range;
    logic                  slot_ready;
    logic [num_sacc_p-1:0] slot_hit;
    logic [num_sacc_p-1:0] has_room;
    logic [num_sacc_p-1:0] cmd_fire;
    logic [num_sacc_p-1:0] resp_fire;
    logic [cnt_w-1:0]      cnt [num_sacc_p];

    bp_cce_mem_msg_s       err_buf_r;
    logic                  err_v_r;
    logic                  err_r;
    logic                  err_fire;

    logic [req_n-1:0]      reqs;
    logic [req_n-1:0]      grants;
    logic                  grant_v;
    logic                  load_en;

    bp_cce_mem_msg_s       resp_sel;
    bp_cce_mem_msg_s       resp_r;
    logic                  resp_v_r;

    assign slot          = io_cmd_i.header.addr[slot_addr_lsb_p +: slot_w];
    assign slot_in_range = ({1'b0, slot} < slot_count);

    // Decode the target slot and whether it can take a command right now.
    always_comb begin
        slot_hit   = '0;
        has_room   = '0;
        slot_ready = 1'b0;
        for (int s = 0; s < num_sacc_p; s++) begin
            has_room[s] = (cnt[s] < cnt_max);
            slot_hit[s] = (slot == slot_w'(s));
            if (slot_hit[s]) begin
                slot_ready = sacc_io_cmd_ready_i[s] & has_room[s];
            end
        end
    end

    // Out-of-range commands are absorbed by the error buffer whenever it is free.
    assign io_cmd_ready_o  = slot_in_range ? slot_ready : !err_v_r;
    assign sacc_io_cmd_o   = {num_sacc_p{io_cmd_i}};
    assign sacc_io_cmd_v_o = {num_sacc_p{io_cmd_v_i & !reset_i}} & slot_hit & has_room;
    assign cmd_fire        = sacc_io_cmd_v_o & sacc_io_cmd_ready_i;
    assign err_fire        = io_cmd_v_i & !slot_in_range & !err_v_r;

    // Credits: +1 per command sent, -1 per response taken, both cancel out.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < num_sacc_p; s++) begin
                cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < num_sacc_p; s++) begin
                case ({cmd_fire[s], resp_fire[s]})
                    2'b10:   cnt[s] <= cnt[s] + cnt_w'(1);
                    2'b01:   if (cnt[s] != '0) cnt[s] <= cnt[s] - cnt_w'(1);
                    default: cnt[s] <= cnt[s];
                endcase
            end
        end
    end

    // One-entry error buffer plus the sticky error flag; the buffer drains
    // when its arbitration slot wins.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_v_r   <= 1'b0;
            err_r     <= 1'b0;
            err_buf_r <= '0;
        end else if (err_fire) begin
            err_v_r   <= 1'b1;
            err_r     <= 1'b1;
            err_buf_r <= '{header: io_cmd_i.header, data: '0};
        end else if (grants[num_sacc_p]) begin
            err_v_r   <= 1'b0;
        end
    end

    assign reqs    = {err_v_r, sacc_io_resp_v_i};
    assign load_en = !resp_v_r | io_resp_yumi_i;

    bsg_arb_round_robin #(
        .width_p (req_n)
    ) arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .grants_en_i (load_en & !reset_i),
        .reqs_i      (reqs),
        .grants_o    (grants),
        .v_o         (grant_v)
    );

    assign resp_fire           = grants[num_sacc_p-1:0];
    assign sacc_io_resp_yumi_o = resp_fire;

    // Select the granted response; the error buffer is the fall-through.
    always_comb begin
        resp_sel = err_buf_r;
        for (int s = 0; s < num_sacc_p; s++) begin
            if (grants[s]) begin
                resp_sel = sacc_io_resp_i[s*msg_w +: msg_w];
            end
        end
    end

    // Output register: loads whenever it is empty or being drained this cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_r <= 1'b0;
            resp_r   <= '0;
        end else if (load_en) begin
            resp_v_r <= grant_v;
            if (grant_v) begin
                resp_r <= resp_sel;
            end
        end
    end

    assign io_resp_o   = resp_r;
    assign io_resp_v_o = resp_v_r;

    // A pending error entry always implies the sticky flag is set.
    a_err_sticky: assert property (@(posedge clk_i) disable iff (reset_i) err_v_r |-> err_r)
        else $error("error buffer holds an entry without the sticky flag");

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grants))
        else $error("more than one response granted in a cycle");

    for (genvar g = 0; g < num_sacc_p; g++) begin : g_credit_chk
        a_no_credit: assert property (@(posedge clk_i) disable iff (reset_i)
                                      resp_fire[g] |-> (cnt[g] != '0))
            else $error("slot %0d response taken with no command outstanding", g);
    end

endmodule
